// File: rtl/cpu_seq.sv
// Variable-length instruction sequencer for the 8-bit CPU: decodes an opcode class and
// steps one control-state code per clock. Optional interrupt entry under CPU_SEQ_IRQ_EN.
module cpu_seq #(
    parameter int INST_W  = 8,
    parameter int STATE_W = 8,
    parameter int CYC_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INST_W-1:0]  instruction,
    input  logic               stall,
    input  logic               resume,
`ifdef CPU_SEQ_IRQ_EN
    input  logic               irq,
    output logic               irq_ack,
`endif
    output logic [STATE_W-1:0] state,
    output logic [CYC_W-1:0]   cycle,
    output logic [7:0]         opcode,
    output logic               inst_done,
    output logic               illegal,
    output logic               halted
);

    if (2**CYC_W < 9) begin : g_cyc_w_check
        $error("cpu_seq: CYC_W must satisfy 2**CYC_W >= 9");
    end
    if (INST_W < 8) begin : g_inst_w_check
        $error("cpu_seq: INST_W must be at least 8");
    end
    if (STATE_W < 5) begin : g_state_w_check
        $error("cpu_seq: STATE_W must be at least 5");
    end

    typedef enum logic [4:0] {
        S_NEXT       = 5'h00,
        S_FETCH_PC   = 5'h01,
        S_FETCH_INST = 5'h02,
        S_HALT       = 5'h03,
        S_JUMP       = 5'h04,
        S_OUT        = 5'h05,
        S_ALU_OUT    = 5'h06,
        S_ALU_EXEC   = 5'h07,
        S_MOV_STORE  = 5'h08,
        S_MOV_FETCH  = 5'h09,
        S_MOV_LOAD   = 5'h0A,
        S_FETCH_SP   = 5'h0C,
        S_PC_STORE   = 5'h0D,
        S_TMP_JUMP   = 5'h0E,
        S_RET        = 5'h0F,
        S_INC_SP     = 5'h10,
        S_SET_ADDR   = 5'h11,
        S_IN         = 5'h12,
        S_REG_STORE  = 5'h13,
        S_SET_REG    = 5'h14,
        S_IRQ_VEC    = 5'h15
    } seq_state_t;

    // OP_BAD is an internal marker for an undecodable class; it is never registered.
    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_CALL = 8'h01,
        OP_RET  = 8'h02,
        OP_OUT  = 8'h03,
        OP_IN   = 8'h04,
        OP_HLT  = 8'h05,
        OP_CMP  = 8'h06,
        OP_LDI  = 8'h10,
        OP_JMP  = 8'h18,
        OP_PUSH = 8'h20,
        OP_POP  = 8'h28,
        OP_ALU  = 8'h40,
        OP_MOV  = 8'h80,
        OP_BAD  = 8'hFF
    } op_t;

    function automatic op_t decode_class(input logic [7:0] b);
        op_t r;
        casez (b)
            8'h00:         r = OP_NOP;
            8'h01:         r = OP_CALL;
            8'h02:         r = OP_RET;
            8'h03:         r = OP_OUT;
            8'h04:         r = OP_IN;
            8'h05:         r = OP_HLT;
            8'h06:         r = OP_CMP;
            8'b00_010_???: r = OP_LDI;
            8'b00_011_???: r = OP_JMP;
            8'b00_100_???: r = OP_PUSH;
            8'b00_101_???: r = OP_POP;
            8'b01_???_000: r = OP_ALU;
            8'b10_??????:  r = OP_MOV;
            default:       r = OP_BAD;
        endcase
        return r;
    endfunction

    // k is the step index after the fetch pair, i.e. cycle-2.
    function automatic seq_state_t class_step(input op_t op, input logic [2:0] k);
        seq_state_t s0, s1, s2, s3, s4, r;
        s0 = S_NEXT; s1 = S_NEXT; s2 = S_NEXT; s3 = S_NEXT; s4 = S_NEXT;
        case (op)
            OP_LDI:  begin s0 = S_FETCH_PC;  s1 = S_SET_REG; end
            OP_JMP:  begin s0 = S_FETCH_PC;  s1 = S_JUMP; end
            OP_MOV:  begin s0 = S_MOV_FETCH; s1 = S_MOV_LOAD; s2 = S_MOV_STORE; end
            OP_ALU:  begin s0 = S_ALU_EXEC;  s1 = S_ALU_OUT; end
            OP_CMP:  begin s0 = S_ALU_EXEC; end
            OP_PUSH: begin s0 = S_FETCH_SP;  s1 = S_REG_STORE; end
            OP_POP:  begin s0 = S_INC_SP;    s1 = S_FETCH_SP; s2 = S_SET_REG; end
            OP_RET:  begin s0 = S_INC_SP;    s1 = S_FETCH_SP; s2 = S_RET; end
            OP_IN:   begin s0 = S_FETCH_PC;  s1 = S_SET_ADDR; s2 = S_IN; end
            OP_OUT:  begin s0 = S_FETCH_PC;  s1 = S_SET_ADDR; s2 = S_OUT; end
            OP_CALL: begin
                s0 = S_FETCH_PC; s1 = S_SET_REG; s2 = S_FETCH_SP;
                s3 = S_PC_STORE; s4 = S_TMP_JUMP;
            end
            OP_HLT:  begin s0 = S_HALT; end
            default: begin s0 = S_NEXT; end
        endcase
        case (k)
            3'd0:    r = s0;
            3'd1:    r = s1;
            3'd2:    r = s2;
            3'd3:    r = s3;
            3'd4:    r = s4;
            default: r = S_NEXT;
        endcase
        return r;
    endfunction

    seq_state_t       cur_state, nxt_state;
    op_t              cur_op, nxt_op, dec_op;
    logic [CYC_W-1:0] nxt_cycle;
    logic             nxt_done, nxt_illegal;
`ifdef CPU_SEQ_IRQ_EN
    logic             irq_mode, nxt_irq_mode;
`endif

    always_comb begin
        dec_op      = decode_class(instruction[INST_W-1 -: 8]);
        nxt_state   = cur_state;
        nxt_cycle   = cycle;
        nxt_op      = cur_op;
        nxt_done    = inst_done;
        nxt_illegal = illegal;
`ifdef CPU_SEQ_IRQ_EN
        nxt_irq_mode = irq_mode;
`endif
        if (!stall) begin
            nxt_done    = 1'b0;
            nxt_illegal = 1'b0;
            if (cur_state == S_HALT) begin
`ifdef CPU_SEQ_IRQ_EN
                if (irq) begin
                    nxt_state    = S_FETCH_SP;
                    nxt_cycle    = CYC_W'(1);
                    nxt_irq_mode = 1'b1;
                end else
`endif
                if (resume) begin
                    nxt_state = S_NEXT;
                    nxt_cycle = '0;
                    nxt_done  = 1'b1;
                end
            end else begin
`ifdef CPU_SEQ_IRQ_EN
                if (irq_mode) begin
                    case (cycle)
                        CYC_W'(1): nxt_state = S_PC_STORE;
                        CYC_W'(2): nxt_state = S_IRQ_VEC;
                        default:   nxt_state = S_NEXT;
                    endcase
                end else if (cycle == '0 && irq) begin
                    nxt_state    = S_FETCH_SP;
                    nxt_irq_mode = 1'b1;
                end else
`endif
                if (cycle > CYC_W'(7)) begin
                    nxt_state   = S_NEXT;
                    nxt_illegal = 1'b1;
                end else if (cycle == '0) begin
                    nxt_state = S_FETCH_PC;
                end else if (cycle == CYC_W'(1)) begin
                    nxt_state = S_FETCH_INST;
                end else if (cycle == CYC_W'(2)) begin
                    if (dec_op == OP_BAD) begin
                        nxt_op      = OP_NOP;
                        nxt_state   = S_NEXT;
                        nxt_illegal = 1'b1;
                    end else begin
                        nxt_op    = dec_op;
                        nxt_state = class_step(dec_op, 3'd0);
                    end
                end else begin
                    nxt_state = class_step(cur_op, 3'(cycle - CYC_W'(2)));
                    // NOP and HLT never legitimately reach a step past decode.
                    if (cur_op == OP_NOP || cur_op == OP_HLT) begin
                        nxt_state   = S_NEXT;
                        nxt_illegal = 1'b1;
                    end
                end
                if (nxt_state == S_NEXT) begin
                    nxt_cycle = '0;
                    nxt_done  = 1'b1;
`ifdef CPU_SEQ_IRQ_EN
                    nxt_irq_mode = 1'b0;
`endif
                end else begin
                    nxt_cycle = cycle + CYC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_state <= S_NEXT;
            cycle     <= '0;
            cur_op    <= OP_NOP;
            inst_done <= 1'b0;
            illegal   <= 1'b0;
            halted    <= 1'b0;
`ifdef CPU_SEQ_IRQ_EN
            irq_mode  <= 1'b0;
            irq_ack   <= 1'b0;
`endif
        end else begin
            cur_state <= nxt_state;
            cycle     <= nxt_cycle;
            cur_op    <= nxt_op;
            inst_done <= nxt_done;
            illegal   <= nxt_illegal;
            halted    <= (nxt_state == S_HALT);
`ifdef CPU_SEQ_IRQ_EN
            irq_mode  <= nxt_irq_mode;
            irq_ack   <= (nxt_state == S_IRQ_VEC);
`endif
        end
    end

    assign state  = STATE_W'(cur_state);
    assign opcode = cur_op;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: walks LDI, CALL, MOV with stall, HLT/resume, illegal
// classes, JMP, CMP, mid-instruction reset and (with CPU_SEQ_IRQ_EN) interrupt entry.
module tb_cpu_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] instruction;
    logic       stall;
    logic       resume;
    logic [7:0] state;
    logic [3:0] cycle;
    logic [7:0] opcode;
    logic       inst_done;
    logic       illegal;
    logic       halted;
`ifdef CPU_SEQ_IRQ_EN
    logic       irq;
    logic       irq_ack;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    cpu_seq #(.INST_W(8), .STATE_W(8), .CYC_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .stall       (stall),
        .resume      (resume),
`ifdef CPU_SEQ_IRQ_EN
        .irq         (irq),
        .irq_ack     (irq_ack),
`endif
        .state       (state),
        .cycle       (cycle),
        .opcode      (opcode),
        .inst_done   (inst_done),
        .illegal     (illegal),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [7:0] st, input logic [3:0] cyc,
                        input logic done);
        tick();
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".cycle"}, 32'(cycle), 32'(cyc));
        check({tag, ".done"},  32'(inst_done), 32'(done));
    endtask

    initial begin
        reset_n     = 1'b0;
        instruction = 8'h10;
        stall       = 1'b0;
        resume      = 1'b0;
`ifdef CPU_SEQ_IRQ_EN
        irq         = 1'b0;
`endif
        tick();
        tick();
        check("rst.state",   32'(state), 32'h00);
        check("rst.cycle",   32'(cycle), 32'h0);
        check("rst.opcode",  32'(opcode), 32'h00);
        check("rst.done",    32'(inst_done), 32'h0);
        check("rst.illegal", 32'(illegal), 32'h0);
        check("rst.halted",  32'(halted), 32'h0);
        reset_n = 1'b1;

        // LDI
        step("ldi0", 8'h01, 4'd1, 1'b0);
        step("ldi1", 8'h02, 4'd2, 1'b0);
        step("ldi2", 8'h01, 4'd3, 1'b0);
        check("ldi.opcode", 32'(opcode), 32'h10);
        step("ldi3", 8'h14, 4'd4, 1'b0);
        step("ldi4", 8'h00, 4'd0, 1'b1);

        // CALL, longest sequence; next fetch follows immediately
        instruction = 8'h01;
        step("call0", 8'h01, 4'd1, 1'b0);
        step("call1", 8'h02, 4'd2, 1'b0);
        step("call2", 8'h01, 4'd3, 1'b0);
        check("call.opcode", 32'(opcode), 32'h01);
        step("call3", 8'h14, 4'd4, 1'b0);
        step("call4", 8'h0C, 4'd5, 1'b0);
        step("call5", 8'h0D, 4'd6, 1'b0);
        step("call6", 8'h0E, 4'd7, 1'b0);
        step("call7", 8'h00, 4'd0, 1'b1);
        instruction = 8'h85;
        step("call.next", 8'h01, 4'd1, 1'b0);

        // MOV with a 3-clock stall in MOV_LOAD
        step("mov1", 8'h02, 4'd2, 1'b0);
        step("mov2", 8'h09, 4'd3, 1'b0);
        check("mov.opcode", 32'(opcode), 32'h80);
        step("mov3", 8'h0A, 4'd4, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step("mov.stall", 8'h0A, 4'd4, 1'b0);
        stall = 1'b0;
        step("mov4", 8'h08, 4'd5, 1'b0);
        step("mov5", 8'h00, 4'd0, 1'b1);
        check("mov.illegal", 32'(illegal), 32'h0);
        stall = 1'b1;
        step("mov.donehold", 8'h00, 4'd0, 1'b1);
        stall = 1'b0;

        // HLT, held 10 clocks, resume blocked by stall then taken
        instruction = 8'h05;
        step("hlt0", 8'h01, 4'd1, 1'b0);
        step("hlt1", 8'h02, 4'd2, 1'b0);
        step("hlt2", 8'h03, 4'd3, 1'b0);
        check("hlt.halted", 32'(halted), 32'h1);
        check("hlt.opcode", 32'(opcode), 32'h05);
        for (int i = 0; i < 9; i++) begin
            step("hlt.hold", 8'h03, 4'd3, 1'b0);
            check("hlt.hold.halted", 32'(halted), 32'h1);
        end
        resume = 1'b1;
        stall  = 1'b1;
        step("hlt.stalled", 8'h03, 4'd3, 1'b0);
        stall  = 1'b0;
        step("hlt.resume", 8'h00, 4'd0, 1'b1);
        check("hlt.unhalted", 32'(halted), 32'h0);
        resume = 1'b0;

        // Illegal classes 01_000_001 and 00_000_111
        instruction = 8'h41;
        step("ill0", 8'h01, 4'd1, 1'b0);
        step("ill1", 8'h02, 4'd2, 1'b0);
        step("ill2", 8'h00, 4'd0, 1'b1);
        check("ill.flag",   32'(illegal), 32'h1);
        check("ill.opcode", 32'(opcode), 32'h00);
        instruction = 8'h07;
        step("ill.next", 8'h01, 4'd1, 1'b0);
        check("ill.clear", 32'(illegal), 32'h0);
        step("ill7.1", 8'h02, 4'd2, 1'b0);
        step("ill7.2", 8'h00, 4'd0, 1'b1);
        check("ill7.flag", 32'(illegal), 32'h1);

        // JMP 00_011_010
        instruction = 8'h1A;
        step("jmp0", 8'h01, 4'd1, 1'b0);
        step("jmp1", 8'h02, 4'd2, 1'b0);
        step("jmp2", 8'h01, 4'd3, 1'b0);
        check("jmp.opcode", 32'(opcode), 32'h18);
        step("jmp3", 8'h04, 4'd4, 1'b0);
        step("jmp4", 8'h00, 4'd0, 1'b1);

        // CMP
        instruction = 8'h06;
        step("cmp0", 8'h01, 4'd1, 1'b0);
        step("cmp1", 8'h02, 4'd2, 1'b0);
        step("cmp2", 8'h07, 4'd3, 1'b0);
        step("cmp3", 8'h00, 4'd0, 1'b1);
        check("cmp.opcode", 32'(opcode), 32'h06);

        // POP aborted by reset; resume outside HALT has no effect
        instruction = 8'h28;
        resume      = 1'b1;
        step("pop0", 8'h01, 4'd1, 1'b0);
        step("pop1", 8'h02, 4'd2, 1'b0);
        step("pop2", 8'h10, 4'd3, 1'b0);
        step("pop3", 8'h0C, 4'd4, 1'b0);
        resume  = 1'b0;
        reset_n = 1'b0;
        step("pop.rst", 8'h00, 4'd0, 1'b0);
        check("pop.rst.opcode", 32'(opcode), 32'h00);
        check("pop.rst.halted", 32'(halted), 32'h0);
        reset_n = 1'b1;

`ifdef CPU_SEQ_IRQ_EN
        irq = 1'b1;
        step("irq0", 8'h0C, 4'd1, 1'b0);
        irq = 1'b0;
        step("irq1", 8'h0D, 4'd2, 1'b0);
        check("irq1.ack", 32'(irq_ack), 32'h0);
        step("irq2", 8'h15, 4'd3, 1'b0);
        check("irq2.ack", 32'(irq_ack), 32'h1);
        step("irq3", 8'h00, 4'd0, 1'b1);
        check("irq3.ack", 32'(irq_ack), 32'h0);
        irq = 1'b1;
        step("irqb0", 8'h0C, 4'd1, 1'b0);
        irq = 1'b0;
        step("irqb1", 8'h0D, 4'd2, 1'b0);
        reset_n = 1'b0;
        step("irqb.rst", 8'h00, 4'd0, 1'b0);
        check("irqb.rst.ack", 32'(irq_ack), 32'h0);
        reset_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
